// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, single-cycle bus access, registered response.
// Misaligned requests bypass the bus and answer one cycle after acceptance.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_exc,
  output logic [3:0]  resp_cause,
  output logic [31:0] resp_badaddr,
  output logic        bus_rw,
  output logic [1:0]  bus_len,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_write,
  input  logic [31:0] bus_read,
  input  logic        bus_exception
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state;
  logic        store_q;
  logic        unsigned_q;
  logic [4:0]  rd_q;
  logic        resp_pulse_q;

  logic [1:0]  dec_size;
  logic        dec_unsigned;
  logic        dec_misaligned;
  logic [31:0] dec_mask;
  logic [31:0] load_ext;

  assign req_ready  = (state == StIdle) && !flush;
  // A flush arriving while the response is up still has to kill it.
  assign resp_valid = resp_pulse_q && !flush;

  // Width decode; unlisted encodings fall back to a word access.
  always_comb begin
    dec_size     = 2'd2;
    dec_unsigned = 1'b0;
    case (req_funct3)
      3'b000: dec_size = 2'd0;
      3'b001: dec_size = 2'd1;
      3'b100: if (!req_store) begin
        dec_size     = 2'd0;
        dec_unsigned = 1'b1;
      end
      3'b101: if (!req_store) begin
        dec_size     = 2'd1;
        dec_unsigned = 1'b1;
      end
      default: dec_size = 2'd2;
    endcase
    dec_misaligned = ((dec_size == 2'd1) && req_addr[0]) ||
                     ((dec_size == 2'd2) && (req_addr[1:0] != 2'b00));
    case (dec_size)
      2'd0:    dec_mask = 32'h0000_00ff;
      2'd1:    dec_mask = 32'h0000_ffff;
      default: dec_mask = 32'hffff_ffff;
    endcase
  end

  always_comb begin
    case (bus_len)
      2'd0:    load_ext = {{24{bus_read[7] & ~unsigned_q}}, bus_read[7:0]};
      2'd1:    load_ext = {{16{bus_read[15] & ~unsigned_q}}, bus_read[15:0]};
      default: load_ext = bus_read;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      store_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      rd_q         <= '0;
      resp_pulse_q <= 1'b0;
      resp_rd      <= '0;
      resp_data    <= '0;
      resp_exc     <= 1'b0;
      resp_cause   <= '0;
      resp_badaddr <= '0;
      bus_rw       <= 1'b0;
      bus_len      <= '0;
      bus_addr     <= '0;
      bus_write    <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid && req_ready) begin
            store_q    <= req_store;
            unsigned_q <= dec_unsigned;
            rd_q       <= req_rd;
            if (dec_misaligned) begin
              resp_pulse_q <= 1'b1;
              resp_rd      <= '0;
              resp_data    <= '0;
              resp_exc     <= 1'b1;
              resp_cause   <= req_store ? 4'd6 : 4'd4;
              resp_badaddr <= req_addr;
              state        <= StDone;
            end else begin
              bus_rw    <= req_store;
              bus_len   <= dec_size;
              bus_addr  <= req_addr;
              bus_write <= req_wdata & dec_mask;
              state     <= StAccess;
            end
          end
        end
        StAccess: begin
          bus_rw       <= 1'b0;
          bus_len      <= '0;
          bus_addr     <= '0;
          bus_write    <= '0;
          resp_pulse_q <= !flush;
          if (bus_exception) begin
            resp_rd      <= '0;
            resp_data    <= '0;
            resp_exc     <= 1'b1;
            resp_cause   <= store_q ? 4'd7 : 4'd5;
            resp_badaddr <= bus_addr;
          end else begin
            resp_rd      <= store_q ? 5'd0 : rd_q;
            resp_data    <= store_q ? 32'd0 : load_ext;
            resp_exc     <= 1'b0;
            resp_cause   <= '0;
            resp_badaddr <= '0;
          end
          state <= StDone;
        end
        StDone: begin
          resp_pulse_q <= 1'b0;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised plus directed bench for load_store_unit against a byte-count based reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_exc;
  logic [3:0]  resp_cause;
  logic [31:0] resp_badaddr;
  logic        bus_rw;
  logic [1:0]  bus_len;
  logic [31:0] bus_addr;
  logic [31:0] bus_write;
  logic [31:0] bus_read = '0;
  logic        bus_exception = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data), .resp_exc(resp_exc),
    .resp_cause(resp_cause), .resp_badaddr(resp_badaddr),
    .bus_rw(bus_rw), .bus_len(bus_len), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_read(bus_read), .bus_exception(bus_exception)
  );

  // Reference: everything derived from the access size in bytes and plain integer arithmetic.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                       input logic bexc, output logic mis, output logic [1:0] len,
                       output logic [31:0] wexp, output logic exc, output logic [3:0] cause,
                       output logic [31:0] bad, output logic [31:0] data,
                       output logic [4:0] rdo);
    int     nbytes;
    longint lim;
    longint raw;
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    lim    = longint'(1) << (8 * nbytes);
    mis    = (longint'(addr) % nbytes) != 0;
    len    = (nbytes == 1) ? 2'd0 : (nbytes == 2) ? 2'd1 : 2'd2;
    wexp   = 32'(longint'(wdata) % lim);
    raw    = longint'(rdata) % lim;
    if (!f3[2] && nbytes < 4 && raw >= lim / 2) raw = raw - lim;
    exc = 1'b0; cause = 4'd0; bad = 32'd0; data = 32'd0; rdo = 5'd0;
    if (mis) begin
      exc = 1'b1; cause = st ? 4'd6 : 4'd4; bad = addr;
    end else if (bexc) begin
      exc = 1'b1; cause = st ? 4'd7 : 4'd5; bad = addr;
    end else if (!st) begin
      data = 32'(raw); rdo = rd;
    end
  endtask

  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] rdata, input logic bexc, input logic do_flush);
    logic mis, exc;
    logic [1:0] len;
    logic [3:0] cause;
    logic [31:0] wexp, bad, data;
    logic [4:0] rdo;
    model(st, f3, addr, wdata, rd, rdata, bexc, mis, len, wexp, exc, cause, bad, data, rdo);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr;
    req_wdata = wdata; req_rd = rd;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_idle: got %b want 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!mis) begin
      vectors++;
      if ({resp_valid, req_ready, bus_rw, bus_len, bus_addr, bus_write} !==
          {1'b0, 1'b0, st, len, addr, wexp}) begin
        miscompares++;
        $display("FAIL bus_access: got v%b r%b rw%b len%0d a%h w%h want v0 r0 rw%b len%0d a%h w%h",
                 resp_valid, req_ready, bus_rw, bus_len, bus_addr, bus_write,
                 st, len, addr, wexp);
      end
      bus_read = rdata; bus_exception = bexc; flush = do_flush;
      @(posedge clk); #1;
      flush = 1'b0; bus_read = $urandom; bus_exception = 1'b0;
      #1;
    end
    vectors++;
    if ({bus_rw, bus_len, bus_addr, bus_write} !== 67'd0) begin
      miscompares++;
      $display("FAIL bus_idle: got rw%b len%0d a%h w%h want all 0",
               bus_rw, bus_len, bus_addr, bus_write);
    end
    vectors++;
    if (do_flush) begin
      if (resp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_suppress: resp_valid got %b want 0", resp_valid);
      end
    end else if ({resp_valid, resp_exc, resp_cause, resp_badaddr, resp_data, resp_rd} !==
                 {1'b1, exc, cause, bad, data, rdo}) begin
      miscompares++;
      $display("FAIL resp: got v%b e%b c%0d b%h d%h rd%0d want v1 e%b c%0d b%h d%h rd%0d",
               resp_valid, resp_exc, resp_cause, resp_badaddr, resp_data, resp_rd,
               exc, cause, bad, data, rdo);
    end
    @(posedge clk); #1;
    vectors++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL resp_pulse_end: got v%b r%b want v0 r1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({resp_valid, resp_rd, resp_data, resp_exc, resp_cause, resp_badaddr,
         bus_rw, bus_len, bus_addr, bus_write} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: some output nonzero (v%b rw%b a%h)",
               resp_valid, bus_rw, bus_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_directed();
    run_op(1'b0, 3'b000, 32'h0000_0401, 32'h0, 5'd3, 32'h0000_0080, 1'b0, 1'b0);
    vectors++;
    if (resp_data !== 32'hffff_ff80 || resp_rd !== 5'd3) begin
      miscompares++;
      $display("FAIL lb_sign: got %h rd%0d want ffffff80 rd3", resp_data, resp_rd);
    end
    run_op(1'b0, 3'b101, 32'h0000_0402, 32'h0, 5'd4, 32'habcd_8001, 1'b0, 1'b0);
    vectors++;
    if (resp_data !== 32'h0000_8001) begin
      miscompares++;
      $display("FAIL lhu_zero: got %h want 00008001", resp_data);
    end
    run_op(1'b0, 3'b010, 32'h0000_0404, 32'h0, 5'd5, 32'hdead_beef, 1'b0, 1'b0);
    run_op(1'b1, 3'b000, 32'h0000_0400, 32'h1234_56a5, 5'd9, 32'h0, 1'b0, 1'b0);
    run_op(1'b0, 3'b010, 32'h0000_0402, 32'h0, 5'd6, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (resp_cause !== 4'd4 || resp_badaddr !== 32'h402) begin
      miscompares++;
      $display("FAIL lw_misaligned: got c%0d b%h want c4 b00000402", resp_cause, resp_badaddr);
    end
    run_op(1'b1, 3'b001, 32'h0000_0401, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0);
    run_op(1'b1, 3'b010, 32'h8000_0000, 32'h5555_aaaa, 5'd0, 32'h0, 1'b1, 1'b0);
    vectors++;
    if (resp_cause !== 4'd7 || resp_data !== 32'd0) begin
      miscompares++;
      $display("FAIL sw_fault: got c%0d d%h want c7 d0", resp_cause, resp_data);
    end
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic st;
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
      if (!st && f3 == 3'd3) f3 = 3'd4;
      else if (!st && f3 == 3'd4) f3 = 3'd5;
      run_op(st, f3, $urandom, $urandom, 5'($urandom), $urandom,
             ($urandom_range(0, 7) == 0), 1'b0);
    end
  endtask

  task automatic test_flush();
    run_op(1'b1, 3'b010, 32'h0000_0800, 32'hcafe_f00d, 5'd0, 32'h0, 1'b0, 1'b1);
    run_op(1'b0, 3'b001, 32'h0000_0806, 32'h0, 5'd7, 32'h0000_7fff, 1'b0, 1'b1);
    // Flush in IDLE must block acceptance.
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h10;
    @(posedge clk); #1;
    vectors++;
    if ({req_ready, bus_rw, bus_addr} !== 34'd0) begin
      miscompares++;
      $display("FAIL flush_idle: got r%b a%h want r0 a0", req_ready, bus_addr);
    end
    req_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0c00;
    req_wdata = 32'h1111_2222;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus_rw, bus_len, bus_addr, bus_write, resp_valid} !== 68'd0) begin
      miscompares++;
      $display("FAIL reset_mid_bus: got rw%b a%h w%h v%b want 0",
               bus_rw, bus_addr, bus_write, resp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_ready: got %b want 1", req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (resp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_noresp: got %b want 0", resp_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    run_op(1'b0, 3'b100, 32'h0000_0013, 32'h0, 5'd1, 32'h0000_00f0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side load/store unit sitting directly upstream of the data bus. It accepts one memory request at a time from the execute stage and decodes RV32I load/store width and signedness. It checks alignment, drives the bus for exactly one cycle, then returns sign/zero-extended load data or an exception to writeback. Bus read data is combinational, so each access costs one bus cycle plus a registered response.

## Interface
- No parameters.
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; kills pending response.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE with flush low.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only).
- req_addr  in  32  effective byte address.
- req_wdata  in  32  store data, LSB-aligned.
- req_rd  in  5  load destination register.
- resp_valid  out  1  one-cycle response pulse.
- resp_rd  out  5  destination; 0 for stores and exceptions.
- resp_data  out  32  extended load data; 0 for stores and exceptions.
- resp_exc  out  1  exception flag.
- resp_cause  out  4  4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault, else 0.
- resp_badaddr  out  32  faulting address when resp_exc, else 0.
- bus_rw  out  1  1 = write.
- bus_len  out  2  0 byte, 1 half, 2 word.
- bus_addr  out  32  byte address.
- bus_write  out  32  LSB-aligned store data, masked to size.
- bus_read  in  32  LSB-aligned read data (combinational from bus).
- bus_exception  in  1  access fault for current address.

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE. All outputs are registered and reset to 0, except req_ready, which is combinational.
- IDLE: a handshake (req_valid & req_ready) latches the request.
  - Illegal funct3 (011, 11x, or 10x on a store) is treated as a word access; the decode tie-break is not checked.
  - Alignment check: half requires addr[0]=0; word requires addr[1:0]=0.
  - Misaligned request: go directly to DONE with cause 4 or 6 and badaddr = req_addr. The bus stays idle.
  - Aligned request: go to ACCESS and load the bus registers.
- ACCESS: the bus is driven for one cycle.
  - bus_rw = req_store; bus_len = funct3[1:0] (10 → 2).
  - bus_write = wdata & mask, with masks 0xFF, 0xFFFF, 0xFFFFFFFF.
  - At the end of the cycle, sample bus_read and bus_exception, then go to DONE.
  - Load result: B sign-extends bit 7, H bit 15; BU/HU zero-extend; W passes through.
  - bus_exception=1: cause 5 (load) or 7 (store), badaddr = bus_addr, data 0, rd 0.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. Response fields hold their values until the next DONE. The bus returns to idle (all zeros) on leaving ACCESS.
- Bus idle value is rw=0, len=0, addr=0, write=0, so downstream address-decoded side effects never see a write outside ACCESS.
- Flush:
  - In IDLE: blocks acceptance.
  - In ACCESS: the bus cycle completes (a store still commits), but the following DONE suppresses resp_valid.
  - In DONE: suppresses resp_valid that cycle.
- Reset mid-operation: asynchronously returns to IDLE and clears the bus outputs immediately. No partial response is emitted after reset.

## Timing
- Aligned request accepted at edge N: bus driven during cycle N..N+1, sampled at edge N+1, resp_valid high in cycle N+1..N+2.
- Misaligned request accepted at edge N: resp_valid high in cycle N..N+1.
- req_ready low in ACCESS and DONE. Maximum throughput is one aligned access per 3 cycles, one misaligned per 2.
- No response back-pressure: the consumer must take resp_valid when it fires.
- bus_read and bus_exception are only meaningful during ACCESS; they are ignored otherwise.

## Test plan
- LB at 0x0000_0401, bus_read=0x0000_0080 → bus_len=0, bus_rw=0 for exactly 1 cycle; resp_data=0xFFFF_FF80, resp_rd=req_rd, 3 cycles request-to-response.
- LHU at 0x402, bus_read=0xABCD_8001 → resp_data=0x0000_8001. LW at 0x404 → data passed unchanged.
- SB at 0x400 with wdata=0x1234_56A5 → bus_rw=1, bus_len=0, bus_write=0x0000_00A5 for one cycle; resp_valid with rd=0, exc=0.
- LW at 0x402 → no bus activity (bus_rw/addr stay 0); resp_exc=1, cause=4, badaddr=0x402 on the cycle after accept. SH at 0x401 → cause=6.
- Bus fault: SW at 0x8000_0000 with bus_exception=1 → cause=7, badaddr=0x8000_0000, data 0.
- Flush and reset:
  - flush asserted during ACCESS of SW: the bus write still occurs and no resp_valid follows.
  - rst_n pulled low in ACCESS: bus outputs go to 0 immediately, state returns to IDLE, and req_ready is high after release.
